// File: rtl/imem_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : imem_prefetch
// Brief   : Instruction-fetch front end. It issues sequential fetches and keeps
//           a PC-tagged response FIFO. Redirects flush the FIFO and discard
//           responses still in flight. The optional macro IMEM_PREFETCH_PERF_EN
//           adds the perf_stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
module imem_prefetch #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
`ifdef IMEM_PREFETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(DATA_W / 8);

    logic [DATA_W-1:0]  r_fifo_data [DEPTH];
    logic [ADDR_W-1:0]  r_fifo_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_wptr, r_rptr;
    logic [c_CNT_W-1:0] r_count, r_outstanding, r_discard;
    logic [ADDR_W-1:0]  r_fetch_pc, r_tag_pc;
    logic               r_run;

    logic [c_CNT_W:0]   w_inflight;
    logic [c_CNT_W-1:0] w_outstanding_nxt;
    logic               w_accept, w_resp, w_drop, w_push, w_pop;

    // r_run holds mem_req low until the first cycle after reset is released
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign mem_req    = r_run & (w_inflight < (c_CNT_W + 1)'(DEPTH)) & ~redirect;
    assign mem_addr   = r_fetch_pc;

    assign w_accept = mem_req & mem_gnt;
    assign w_resp   = mem_rvalid & (r_outstanding != '0);
    assign w_drop   = w_resp & (r_discard != '0);
    assign w_push   = w_resp & ~w_drop & ~redirect;
    assign w_pop    = inst_valid & inst_ready & ~redirect;

    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_fifo_data[r_rptr] : '0;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_rptr]   : '0;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_accept && !w_resp) begin
            w_outstanding_nxt = r_outstanding + c_CNT_W'(1);
        end else if (!w_accept && w_resp) begin
            w_outstanding_nxt = r_outstanding - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_tag_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_outstanding_nxt;
            if (redirect) begin
                // Everything still in flight belongs to the abandoned path
                r_fetch_pc <= redirect_pc;
                r_tag_pc   <= redirect_pc;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_discard  <= w_outstanding_nxt;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + c_STEP;
                end
                if (w_drop) begin
                    r_discard <= r_discard - c_CNT_W'(1);
                end
                if (w_push) begin
                    r_tag_pc <= r_tag_pc + c_STEP;
                    r_wptr   <= r_wptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked by inst_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= mem_rdata;
            r_fifo_pc[r_wptr]   <= r_tag_pc;
        end
    end

`ifdef IMEM_PREFETCH_PERF_EN
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
        end else if (inst_ready && !inst_valid && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
`default_nettype wire
